// File: rtl/mips_perf_cnt.sv
// Eight MIPS performance counters under an IDLE/RUN/HALT run-control FSM; 1-cycle register latency.
// Counting happens only in RUN; counts are frozen in HALT and zeroed by reset or cnt_clr.
module mips_perf_cnt #(
    parameter int CNT_WIDTH = 32,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_clr,
    input  logic                 halt,
    input  logic                 inst_valid,
    input  logic                 inst_is_branch,
    input  logic                 inst_is_load,
    input  logic                 inst_is_store,
    input  logic [2:0]           user_evt,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] inst_cnt,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] ld_cnt,
    output logic [CNT_WIDTH-1:0] st_cnt,
    output logic [CNT_WIDTH-1:0] user1_cnt,
    output logic [CNT_WIDTH-1:0] user2_cnt,
    output logic [CNT_WIDTH-1:0] user3_cnt,
    output logic [1:0]           cnt_state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q [8];
    logic [CNT_WIDTH-1:0] cnt_d [8];
    logic [7:0]           evt;

    // Bit order matches cnt_q: cycle, inst, br, ld, st, user1..user3.
    always_comb begin
        evt = {user_evt,
               inst_valid & inst_is_store,
               inst_valid & inst_is_load,
               inst_valid & inst_is_branch,
               inst_valid,
               1'b1};
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (evt[i] && !(SATURATE && (&cnt_q[i]))) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else if (cnt_clr) begin
            state_q <= IDLE;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
                    if (halt) state_q <= HALT;
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cycle_cnt = cnt_q[0];
    assign inst_cnt  = cnt_q[1];
    assign br_cnt    = cnt_q[2];
    assign ld_cnt    = cnt_q[3];
    assign st_cnt    = cnt_q[4];
    assign user1_cnt = cnt_q[5];
    assign user2_cnt = cnt_q[6];
    assign user3_cnt = cnt_q[7];
    assign cnt_state = state_q;

endmodule

// File: tb/tb_mips_perf_cnt.sv
// Directed bench for mips_perf_cnt: a 32-bit saturating instance plus 4-bit saturating and wrapping instances.
module tb_mips_perf_cnt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_clr = 1'b0;
    logic       halt = 1'b0;
    logic       inst_valid = 1'b0;
    logic       inst_is_branch = 1'b0;
    logic       inst_is_load = 1'b0;
    logic       inst_is_store = 1'b0;
    logic [2:0] user_evt = 3'b000;

    logic [31:0] cnt [8];
    logic [1:0]  cnt_state;
    logic [3:0]  s_cnt [8];
    logic [1:0]  s_state;
    logic [3:0]  w_cnt [8];
    logic [1:0]  w_state;

    int n_vec = 0;
    int n_err = 0;
    string nm [8] = '{"cycle", "inst", "br", "ld", "st", "user1", "user2", "user3"};

    always #5 clk = ~clk;

    mips_perf_cnt #(.CNT_WIDTH(32), .SATURATE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .halt(halt),
        .inst_valid(inst_valid), .inst_is_branch(inst_is_branch),
        .inst_is_load(inst_is_load), .inst_is_store(inst_is_store), .user_evt(user_evt),
        .cycle_cnt(cnt[0]), .inst_cnt(cnt[1]), .br_cnt(cnt[2]), .ld_cnt(cnt[3]),
        .st_cnt(cnt[4]), .user1_cnt(cnt[5]), .user2_cnt(cnt[6]), .user3_cnt(cnt[7]),
        .cnt_state(cnt_state)
    );

    mips_perf_cnt #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .halt(halt),
        .inst_valid(inst_valid), .inst_is_branch(inst_is_branch),
        .inst_is_load(inst_is_load), .inst_is_store(inst_is_store), .user_evt(user_evt),
        .cycle_cnt(s_cnt[0]), .inst_cnt(s_cnt[1]), .br_cnt(s_cnt[2]), .ld_cnt(s_cnt[3]),
        .st_cnt(s_cnt[4]), .user1_cnt(s_cnt[5]), .user2_cnt(s_cnt[6]), .user3_cnt(s_cnt[7]),
        .cnt_state(s_state)
    );

    mips_perf_cnt #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .halt(halt),
        .inst_valid(inst_valid), .inst_is_branch(inst_is_branch),
        .inst_is_load(inst_is_load), .inst_is_store(inst_is_store), .user_evt(user_evt),
        .cycle_cnt(w_cnt[0]), .inst_cnt(w_cnt[1]), .br_cnt(w_cnt[2]), .ld_cnt(w_cnt[3]),
        .st_cnt(w_cnt[4]), .user1_cnt(w_cnt[5]), .user2_cnt(w_cnt[6]), .user3_cnt(w_cnt[7]),
        .cnt_state(w_state)
    );

    // Inputs change and outputs are sampled only at falling edges.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic set_inst(input logic v, input logic b, input logic l, input logic s);
        inst_valid = v; inst_is_branch = b; inst_is_load = l; inst_is_store = s;
    endtask

    task automatic test_reset;
        logic [31:0] exp [8];
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== 32'd0) begin
                n_err++; $display("FAIL reset.%s: got %0d want 0", nm[i], cnt[i]);
            end
        end
        n_vec++;
        if (cnt_state !== 2'b00) begin
            n_err++; $display("FAIL reset.state: got %b want 00", cnt_state);
        end
        rst = 1'b0;
        tick(1);
        n_vec++;
        if (cnt_state !== 2'b01 || cnt[0] !== 32'd0) begin
            n_err++; $display("FAIL release.edge1: state %b cycle %0d want 01/0", cnt_state, cnt[0]);
        end
        tick(10);
        exp = '{32'd10, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== exp[i]) begin
                n_err++; $display("FAIL release.%s: got %0d want %0d", nm[i], cnt[i], exp[i]);
            end
        end
    endtask

    task automatic test_event_mix;
        logic [31:0] exp [8];
        set_inst(1, 1, 0, 0); tick(1);
        set_inst(1, 0, 1, 0); tick(1);
        set_inst(1, 0, 0, 1); tick(1);
        set_inst(1, 1, 0, 0); tick(1);
        set_inst(1, 0, 1, 1); tick(1);
        set_inst(1, 0, 0, 0); tick(1);
        set_inst(0, 1, 0, 0); tick(2);
        set_inst(0, 0, 0, 0);
        exp = '{32'd18, 32'd6, 32'd2, 32'd2, 32'd2, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== exp[i]) begin
                n_err++; $display("FAIL mix.%s: got %0d want %0d", nm[i], cnt[i], exp[i]);
            end
        end
    endtask

    task automatic test_halt;
        logic [31:0] exp [8];
        tick(2);
        n_vec++;
        if (cnt[0] !== 32'd20) begin
            n_err++; $display("FAIL halt.pre_cycle: got %0d want 20", cnt[0]);
        end
        halt = 1'b1; set_inst(1, 0, 0, 0);
        tick(1);
        halt = 1'b0;
        n_vec++;
        if (cnt_state !== 2'b10 || cnt[0] !== 32'd21 || cnt[1] !== 32'd7) begin
            n_err++; $display("FAIL halt.edge: state %b cycle %0d inst %0d want 10/21/7",
                              cnt_state, cnt[0], cnt[1]);
        end
        set_inst(1, 1, 1, 1); user_evt = 3'b111;
        for (int k = 0; k < 50; k++) begin
            halt = k[0];
            tick(1);
        end
        halt = 1'b0; set_inst(0, 0, 0, 0); user_evt = 3'b000;
        exp = '{32'd21, 32'd7, 32'd2, 32'd2, 32'd2, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== exp[i]) begin
                n_err++; $display("FAIL halt.frozen.%s: got %0d want %0d", nm[i], cnt[i], exp[i]);
            end
        end
        n_vec++;
        if (cnt_state !== 2'b10) begin
            n_err++; $display("FAIL halt.hold_state: got %b want 10", cnt_state);
        end
    endtask

    task automatic test_clear_priority;
        logic [31:0] exp [8];
        cnt_clr = 1'b1; halt = 1'b1; user_evt = 3'b111;
        tick(1);
        cnt_clr = 1'b0; halt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== 32'd0) begin
                n_err++; $display("FAIL clr.%s: got %0d want 0", nm[i], cnt[i]);
            end
        end
        n_vec++;
        if (cnt_state !== 2'b00) begin
            n_err++; $display("FAIL clr.state: got %b want 00", cnt_state);
        end
        tick(1);
        n_vec++;
        if (cnt_state !== 2'b01 || cnt[5] !== 32'd0) begin
            n_err++; $display("FAIL clr.restart: state %b user1 %0d want 01/0", cnt_state, cnt[5]);
        end
        user_evt = 3'b101;
        tick(3);
        user_evt = 3'b000;
        exp = '{32'd3, 0, 0, 0, 0, 32'd3, 32'd0, 32'd3};
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (cnt[i] !== exp[i]) begin
                n_err++; $display("FAIL clr.user.%s: got %0d want %0d", nm[i], cnt[i], exp[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        tick(34);
        n_vec++;
        if (cnt[0] !== 32'd37) begin
            n_err++; $display("FAIL arst.pre_cycle: got %0d want 37", cnt[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (cnt[0] !== 32'd0 || cnt[5] !== 32'd0 || cnt[7] !== 32'd0 || cnt_state !== 2'b00) begin
            n_err++; $display("FAIL arst.immediate: cycle %0d user1 %0d user3 %0d state %b want 0/0/0/00",
                              cnt[0], cnt[5], cnt[7], cnt_state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_overflow;
        tick(1);
        n_vec++;
        if (s_state !== 2'b01 || w_state !== 2'b01) begin
            n_err++; $display("FAIL ovf.run: sat %b wrap %b want 01/01", s_state, w_state);
        end
        tick(15);
        n_vec++;
        if (s_cnt[0] !== 4'd15 || w_cnt[0] !== 4'd15) begin
            n_err++; $display("FAIL ovf.at15: sat %0d wrap %0d want 15/15", s_cnt[0], w_cnt[0]);
        end
        tick(1);
        n_vec++;
        if (s_cnt[0] !== 4'd15 || w_cnt[0] !== 4'd0) begin
            n_err++; $display("FAIL ovf.edge16: sat %0d wrap %0d want 15/0", s_cnt[0], w_cnt[0]);
        end
        tick(1);
        n_vec++;
        if (w_cnt[0] !== 4'd1) begin
            n_err++; $display("FAIL ovf.wrap17: got %0d want 1", w_cnt[0]);
        end
        tick(3);
        n_vec++;
        if (s_cnt[0] !== 4'd15 || cnt[0] !== 32'd20 || w_cnt[0] !== 4'd4) begin
            n_err++; $display("FAIL ovf.edge20: sat %0d main %0d wrap %0d want 15/20/4",
                              s_cnt[0], cnt[0], w_cnt[0]);
        end
    endtask

    initial begin
        test_reset;
        test_event_mix;
        test_halt;
        test_clear_priority;
        test_async_reset;
        test_overflow;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
